// File: rtl/gci_std_display_bus_queue.sv
// Command/response buffer between the GCI bus master and the display device port.
// Commands queue in order; write acks are dropped, read data is returned through a credit-managed buffer.
module gci_std_display_bus_queue #(
    parameter int CMD_DEPTH   = 8,
    parameter int CMD_DEPTH_N = 3,
    parameter int RD_DEPTH    = 4,
    parameter int RD_DEPTH_N  = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iIF_REQ,
    output logic        oIF_BUSY,
    input  logic        iIF_RW,
    input  logic [31:0] iIF_ADDR,
    input  logic [31:0] iIF_DATA,
    output logic        oIF_REQ,
    input  logic        iIF_BUSY,
    output logic [31:0] oIF_DATA,
    output logic        oDEV_REQ,
    input  logic        iDEV_BUSY,
    output logic        oDEV_RW,
    output logic [31:0] oDEV_ADDR,
    output logic [31:0] oDEV_DATA,
    input  logic        iDEV_REQ,
    input  logic [31:0] iDEV_DATA,
    output logic        oIDLE,
    output logic        oERR_UNEXP
);

    logic              cmd_rw_mem   [CMD_DEPTH];
    logic [31:0]       cmd_addr_mem [CMD_DEPTH];
    logic [31:0]       cmd_data_mem [CMD_DEPTH];
    logic              tag_mem      [CMD_DEPTH];
    logic [31:0]       rd_mem       [RD_DEPTH];

    logic [CMD_DEPTH_N-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
    logic [CMD_DEPTH_N:0]   cmd_count_reg;
    logic [CMD_DEPTH_N-1:0] tag_wr_ptr_reg, tag_rd_ptr_reg;
    logic [CMD_DEPTH_N:0]   tag_count_reg;
    logic [CMD_DEPTH_N:0]   rd_inflight_reg;
    logic [RD_DEPTH_N-1:0]  rd_wr_ptr_reg, rd_rd_ptr_reg;
    logic [RD_DEPTH_N:0]    rd_count_reg;
    logic                   err_reg;

    logic                   cmd_empty, cmd_push, head_rw;
    logic                   tag_ok, rd_ok, dev_accept;
    logic                   tag_valid, tag_pop, rd_push, rd_pop;
    logic [CMD_DEPTH_N+1:0] credit_sum;

    assign cmd_empty = (cmd_count_reg == '0);
    assign oIF_BUSY  = (cmd_count_reg == (CMD_DEPTH_N+1)'(CMD_DEPTH));
    assign cmd_push  = iIF_REQ && !oIF_BUSY;

    // Show-ahead head; forced to zero so stale storage never leaks out when empty.
    assign head_rw   = cmd_empty ? 1'b0  : cmd_rw_mem[cmd_rd_ptr_reg];
    assign oDEV_RW   = head_rw;
    assign oDEV_ADDR = cmd_empty ? 32'd0 : cmd_addr_mem[cmd_rd_ptr_reg];
    assign oDEV_DATA = cmd_empty ? 32'd0 : cmd_data_mem[cmd_rd_ptr_reg];

    // A read may only issue if its data is guaranteed a slot in the read buffer.
    assign credit_sum = (CMD_DEPTH_N+2)'(rd_inflight_reg) + (CMD_DEPTH_N+2)'(rd_count_reg);
    assign tag_ok     = (tag_count_reg < (CMD_DEPTH_N+1)'(CMD_DEPTH));
    assign rd_ok      = head_rw || (credit_sum < (CMD_DEPTH_N+2)'(RD_DEPTH));
    assign oDEV_REQ   = !cmd_empty && tag_ok && rd_ok;
    assign dev_accept = oDEV_REQ && !iDEV_BUSY;

    assign tag_valid = (tag_count_reg != '0);
    assign tag_pop   = iDEV_REQ && tag_valid;
    assign rd_push   = tag_pop && !tag_mem[tag_rd_ptr_reg];

    assign oIF_REQ  = (rd_count_reg != '0);
    assign oIF_DATA = oIF_REQ ? rd_mem[rd_rd_ptr_reg] : 32'd0;
    assign rd_pop   = oIF_REQ && !iIF_BUSY;

    assign oIDLE      = cmd_empty && !tag_valid && !oIF_REQ;
    assign oERR_UNEXP = err_reg;

    always_ff @(posedge iCLOCK) begin
        if (cmd_push) begin
            cmd_rw_mem[cmd_wr_ptr_reg]   <= iIF_RW;
            cmd_addr_mem[cmd_wr_ptr_reg] <= iIF_ADDR;
            cmd_data_mem[cmd_wr_ptr_reg] <= iIF_DATA;
        end
        if (dev_accept) begin
            tag_mem[tag_wr_ptr_reg] <= head_rw;
        end
        if (rd_push) begin
            rd_mem[rd_wr_ptr_reg] <= iDEV_DATA;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            cmd_wr_ptr_reg  <= '0;
            cmd_rd_ptr_reg  <= '0;
            cmd_count_reg   <= '0;
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            tag_count_reg   <= '0;
            rd_inflight_reg <= '0;
            rd_wr_ptr_reg   <= '0;
            rd_rd_ptr_reg   <= '0;
            rd_count_reg    <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (cmd_push)   cmd_wr_ptr_reg <= cmd_wr_ptr_reg + 1'b1;
            if (dev_accept) cmd_rd_ptr_reg <= cmd_rd_ptr_reg + 1'b1;
            case ({cmd_push, dev_accept})
                2'b10:   cmd_count_reg <= cmd_count_reg + 1'b1;
                2'b01:   cmd_count_reg <= cmd_count_reg - 1'b1;
                default: cmd_count_reg <= cmd_count_reg;
            endcase

            if (dev_accept) tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
            if (tag_pop)    tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
            case ({dev_accept, tag_pop})
                2'b10:   tag_count_reg <= tag_count_reg + 1'b1;
                2'b01:   tag_count_reg <= tag_count_reg - 1'b1;
                default: tag_count_reg <= tag_count_reg;
            endcase

            case ({dev_accept && !head_rw, rd_push})
                2'b10:   rd_inflight_reg <= rd_inflight_reg + 1'b1;
                2'b01:   rd_inflight_reg <= rd_inflight_reg - 1'b1;
                default: rd_inflight_reg <= rd_inflight_reg;
            endcase

            if (rd_push) rd_wr_ptr_reg <= rd_wr_ptr_reg + 1'b1;
            if (rd_pop)  rd_rd_ptr_reg <= rd_rd_ptr_reg + 1'b1;
            case ({rd_push, rd_pop})
                2'b10:   rd_count_reg <= rd_count_reg + 1'b1;
                2'b01:   rd_count_reg <= rd_count_reg - 1'b1;
                default: rd_count_reg <= rd_count_reg;
            endcase

            if (iDEV_REQ && !tag_valid) err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gci_std_display_bus_queue.sv
// Directed bench for gci_std_display_bus_queue: ordering, back-pressure, read credit, error flag, reset.
module tb_gci_std_display_bus_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_rw, if_busy_in;
    logic [31:0] if_addr, if_data;
    logic        if_busy, if_req_out, dev_req, dev_rw, idle, err_unexp;
    logic [31:0] if_data_out, dev_addr, dev_data;
    logic        dev_busy, dev_req_in;
    logic [31:0] dev_data_in;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gci_std_display_bus_queue dut (
        .iCLOCK    (clk),
        .inRESET   (rst_n),
        .iIF_REQ   (if_req),
        .oIF_BUSY  (if_busy),
        .iIF_RW    (if_rw),
        .iIF_ADDR  (if_addr),
        .iIF_DATA  (if_data),
        .oIF_REQ   (if_req_out),
        .iIF_BUSY  (if_busy_in),
        .oIF_DATA  (if_data_out),
        .oDEV_REQ  (dev_req),
        .iDEV_BUSY (dev_busy),
        .oDEV_RW   (dev_rw),
        .oDEV_ADDR (dev_addr),
        .oDEV_DATA (dev_data),
        .iDEV_REQ  (dev_req_in),
        .iDEV_DATA (dev_data_in),
        .oIDLE     (idle),
        .oERR_UNEXP(err_unexp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic req, input logic rw, input logic [31:0] a, input logic [31:0] d);
        if_req  = req;
        if_rw   = rw;
        if_addr = a;
        if_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        if_busy_in = 1'b0;
        dev_busy = 1'b0;
        dev_req_in = 1'b0;
        dev_data_in = 32'd0;
        step();
        chk("rst_if_busy", {31'd0, if_busy}, 32'd0);
        chk("rst_if_req", {31'd0, if_req_out}, 32'd0);
        chk("rst_if_data", if_data_out, 32'd0);
        chk("rst_dev_req", {31'd0, dev_req}, 32'd0);
        chk("rst_dev_addr", dev_addr, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_err", {31'd0, err_unexp}, 32'd0);
        rst_n = 1'b1;
        step();

        // T1: single write, ack dropped
        set_cmd(1'b1, 1'b1, 32'h400, 32'h00FF_F041);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t1_dev_req", {31'd0, dev_req}, 32'd1);
        chk("t1_dev_addr", dev_addr, 32'h400);
        chk("t1_dev_rw", {31'd0, dev_rw}, 32'd1);
        chk("t1_dev_data", dev_data, 32'h00FF_F041);
        step();
        chk("t1_dev_req_after", {31'd0, dev_req}, 32'd0);
        chk("t1_busy_tag", {31'd0, idle}, 32'd0);
        dev_req_in = 1'b1; dev_data_in = 32'hDEAD_BEEF;
        step();
        dev_req_in = 1'b0;
        chk("t1_if_req", {31'd0, if_req_out}, 32'd0);
        chk("t1_idle", {31'd0, idle}, 32'd1);

        // T2: single read, data held while master busy
        set_cmd(1'b1, 1'b0, 32'h8, 32'd0);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t2_dev_req", {31'd0, dev_req}, 32'd1);
        chk("t2_dev_rw", {31'd0, dev_rw}, 32'd0);
        step();
        if_busy_in = 1'b1;
        dev_req_in = 1'b1; dev_data_in = 32'h2;
        step();
        dev_req_in = 1'b0;
        chk("t2_if_req", {31'd0, if_req_out}, 32'd1);
        chk("t2_if_data", if_data_out, 32'h2);
        step();
        chk("t2_if_req_held", {31'd0, if_req_out}, 32'd1);
        chk("t2_if_data_held", if_data_out, 32'h2);
        if_busy_in = 1'b0;
        step();
        chk("t2_if_req_done", {31'd0, if_req_out}, 32'd0);
        chk("t2_idle", {31'd0, idle}, 32'd1);

        // T3: fill command FIFO while device busy
        dev_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_cmd(1'b1, 1'b1, 32'h100 + i, i);
            chk($sformatf("t3_if_busy_%0d", i), {31'd0, if_busy}, (i == 8) ? 32'd1 : 32'd0);
            step();
        end
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t3_full", {31'd0, if_busy}, 32'd1);
        chk("t3_dev_req_stall", {31'd0, dev_req}, 32'd1);
        chk("t3_head_stall", dev_addr, 32'h100);
        dev_busy = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t3_issue_req_%0d", j), {31'd0, dev_req}, 32'd1);
            chk($sformatf("t3_issue_addr_%0d", j), dev_addr, 32'h100 + j);
            step();
        end
        chk("t3_drained", {31'd0, dev_req}, 32'd0);
        chk("t3_not_full", {31'd0, if_busy}, 32'd0);
        dev_req_in = 1'b1;
        for (int j = 0; j < 8; j++) step();
        dev_req_in = 1'b0;
        chk("t3_idle", {31'd0, idle}, 32'd1);
        chk("t3_err", {31'd0, err_unexp}, 32'd0);

        // T4: read credit limits issue to the buffer depth
        if_busy_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_cmd(1'b1, 1'b0, 32'h10 + i, 32'd0);
            step();
        end
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        chk("t4_blocked", {31'd0, dev_req}, 32'd0);
        chk("t4_head_addr", dev_addr, 32'h14);
        chk("t4_head_rw", {31'd0, dev_rw}, 32'd0);
        dev_req_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            dev_data_in = 32'hA0 + j;
            step();
        end
        dev_req_in = 1'b0;
        chk("t4_still_blocked", {31'd0, dev_req}, 32'd0);
        chk("t4_if_req", {31'd0, if_req_out}, 32'd1);
        chk("t4_if_data0", if_data_out, 32'hA0);
        if_busy_in = 1'b0;
        step();
        if_busy_in = 1'b1;
        chk("t4_if_data1", if_data_out, 32'hA1);
        chk("t4_fifth_issues", {31'd0, dev_req}, 32'd1);
        chk("t4_fifth_addr", dev_addr, 32'h14);
        step();
        chk("t4_sixth_blocked", {31'd0, dev_req}, 32'd0);
        chk("t4_sixth_addr", dev_addr, 32'h15);
        dev_req_in = 1'b1; dev_data_in = 32'hA4;
        step();
        dev_req_in = 1'b0;
        if_busy_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t4_pop_%0d", j), if_data_out, 32'hA1 + j);
            step();
        end
        chk("t4_buf_empty", {31'd0, if_req_out}, 32'd0);
        dev_req_in = 1'b1; dev_data_in = 32'hA5;
        step();
        dev_req_in = 1'b0;
        chk("t4_last_req", {31'd0, if_req_out}, 32'd1);
        chk("t4_last_data", if_data_out, 32'hA5);
        step();
        chk("t4_idle", {31'd0, idle}, 32'd1);

        // T5: write/read/write, only read data returns
        if_busy_in = 1'b1;
        set_cmd(1'b1, 1'b1, 32'h200, 32'h1);
        step();
        set_cmd(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        set_cmd(1'b1, 1'b1, 32'h204, 32'h2);
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("t5_issued", {31'd0, dev_req}, 32'd0);
        dev_req_in = 1'b1;
        dev_data_in = 32'h111;
        step();
        dev_data_in = 32'h55;
        step();
        dev_data_in = 32'h333;
        step();
        dev_req_in = 1'b0;
        chk("t5_if_req", {31'd0, if_req_out}, 32'd1);
        chk("t5_if_data", if_data_out, 32'h55);
        if_busy_in = 1'b0;
        step();
        chk("t5_single_entry", {31'd0, if_req_out}, 32'd0);
        chk("t5_idle", {31'd0, idle}, 32'd1);
        chk("t5_err", {31'd0, err_unexp}, 32'd0);

        // T6: unexpected response, then reset mid-burst
        dev_req_in = 1'b1; dev_data_in = 32'h77;
        step();
        dev_req_in = 1'b0;
        chk("t6_err_set", {31'd0, err_unexp}, 32'd1);
        chk("t6_no_data", {31'd0, if_req_out}, 32'd0);
        step();
        chk("t6_err_sticky", {31'd0, err_unexp}, 32'd1);
        dev_busy = 1'b1;
        set_cmd(1'b1, 1'b1, 32'h300, 32'h9);
        step();
        step();
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t6_pending", {31'd0, dev_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dev_req", {31'd0, dev_req}, 32'd0);
        chk("t6_rst_dev_addr", dev_addr, 32'd0);
        chk("t6_rst_dev_data", dev_data, 32'd0);
        chk("t6_rst_if_busy", {31'd0, if_busy}, 32'd0);
        chk("t6_rst_if_req", {31'd0, if_req_out}, 32'd0);
        chk("t6_rst_idle", {31'd0, idle}, 32'd1);
        chk("t6_rst_err", {31'd0, err_unexp}, 32'd0);
        step();
        rst_n = 1'b1;
        dev_busy = 1'b0;
        step();
        chk("t6_post_idle", {31'd0, idle}, 32'd1);
        chk("t6_post_dev_req", {31'd0, dev_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
